ysyx_22040632_wbu: RTL

//  Writeback/commit unit; the consumer end of the EXU result interface (data, rd write-enable, pcchg, pc target).

---
 rtl/ysyx_22040632_RISCV_PKG.sv | 20 ++
 rtl/ysyx_22040632_wb_fifo.sv | 66 ++++++
 rtl/ysyx_22040632_wbu.sv | 97 +++++++++
 3 files changed

// File: rtl/ysyx_22040632_RISCV_PKG.sv
// Shared RISC-V core definitions: datapath width, reset PC and the
// writeback entry carried from EXU to WBU.
package ysyx_22040632_RISCV_PKG;

  localparam int XLEN       = 64;
  localparam int NREG       = 32;
  localparam int FIFO_DEPTH = 2;

  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            wen;
    logic [4:0]      rd;
    logic            pcchg;
    logic [XLEN-1:0] pc_op;
    logic [XLEN-1:0] pc;
  } wb_entry_t;

endpackage

// File: rtl/ysyx_22040632_wb_fifo.sv
// Synchronous FIFO of writeback entries. Exposes every slot plus a per-slot
// valid vector so the top level can scan pending destinations.
module ysyx_22040632_wb_fifo
  import ysyx_22040632_RISCV_PKG::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_entry_t             din,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output wb_entry_t             head,
  output logic      [DEPTH-1:0] valid,
  output wb_entry_t [DEPTH-1:0] entries
);

  localparam int AW = $clog2(DEPTH);

  logic      [AW:0]      wr_ptr;
  logic      [AW:0]      rd_ptr;
  logic      [AW:0]      count;
  logic      [AW-1:0]    off;
  wb_entry_t [DEPTH-1:0] mem;
  logic                  do_push;
  logic                  do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign entries = mem;
  assign count   = wr_ptr - rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers and valid vector decide which slots mean anything.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Slot i is live when its distance from the read index is below the occupancy.
  always_comb begin
    // NOTE: defaults first so no path through the loop can infer a latch.
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = AW'(i) - rd_ptr[AW-1:0];
      valid[i] = ({1'b0, off} < count);
    end
  end

endmodule

// File: rtl/ysyx_22040632_wbu.sv
// Writeback/commit unit: buffers EXU results, retires one per cycle into the
// GPR file and architectural PC, and flags registers with pending writes.
module ysyx_22040632_wbu
  import ysyx_22040632_RISCV_PKG::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_data,
  input  logic            ex_wen,
  input  logic [4:0]      ex_rd,
  input  logic            ex_pcchg,
  input  logic [XLEN-1:0] ex_pc_op,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            wb_stall,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [XLEN-1:0] pc,
  output logic            commit,
  output logic [63:0]     commit_cnt
);

  wb_entry_t                  push_entry;
  wb_entry_t                  head;
  wb_entry_t [FIFO_DEPTH-1:0] entries;
  logic      [FIFO_DEPTH-1:0] valid;
  logic                       full;
  logic                       empty;
  logic                       fire;
  logic      [XLEN-1:0]       gpr [NREG];
  logic      [XLEN-1:0]       next_pc;

  assign push_entry = '{data: ex_data, wen: ex_wen, rd: ex_rd, pcchg: ex_pcchg,
                        pc_op: ex_pc_op, pc: ex_pc};
  assign ex_ready   = !full;
  assign fire       = !empty && !wb_stall;

  ysyx_22040632_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (ex_valid),
    .din     (push_entry),
    .pop     (fire),
    .full    (full),
    .empty   (empty),
    .head    (head),
    .valid   (valid),
    .entries (entries)
  );

  // Jump targets have bit 0 cleared; sequential flow wraps modulo 2^XLEN.
  assign next_pc = head.pcchg ? (head.pc_op & ~{{(XLEN-1){1'b0}}, 1'b1})
                              : head.pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      commit     <= 1'b0;
      commit_cnt <= '0;
    end else begin
      commit <= fire;
      if (fire) begin
        pc         <= next_pc;
        commit_cnt <= commit_cnt + 64'd1;
      end
    end
  end

  // The register file must read as zero after reset, so it is cleared explicitly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else if (fire && head.wen && (head.rd != 5'd0)) begin
      gpr[head.rd] <= head.data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : gpr[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : gpr[rs2_addr];

  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (valid[i] && entries[i].wen) begin
        if (entries[i].rd == rs1_addr && rs1_addr != 5'd0) rs1_busy = 1'b1;
        if (entries[i].rd == rs2_addr && rs2_addr != 5'd0) rs2_busy = 1'b1;
      end
    end
  end

endmodule
